// File: rtl/tri_raster_fb.sv
// Renders up to N_TRI flat-coloured triangles into the frame buffer in raster order.
// 3-cycle pixel pipeline from start to first write; the whole pipeline holds while a write is unacked.
module tri_raster_fb #(
  parameter int N_TRI    = 4,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COORD_W  = 12,
  parameter int ADDR_W   = 18
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_idx,
  input  logic [2:0]         cfg_sel,
  input  logic [COORD_W-1:0] cfg_data,
  input  logic [11:0]        bg_color,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               wr_req,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [15:0]        wr_data,
  input  logic               wr_ack
);

  localparam int DW = COORD_W + 1;
  localparam int PW = 2 * COORD_W + 2;
  localparam int EW = 2 * COORD_W + 3;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_ACTIVE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nx;
  logic   accept;
  logic   advance;

  logic [COORD_W-1:0] sh_x  [N_TRI][3];
  logic [COORD_W-1:0] sh_y  [N_TRI][3];
  logic [COORD_W-1:0] nx_x  [N_TRI][3];
  logic [COORD_W-1:0] nx_y  [N_TRI][3];
  logic [COORD_W-1:0] act_x [N_TRI][3];
  logic [COORD_W-1:0] act_y [N_TRI][3];
  logic [11:0]        sh_col  [N_TRI];
  logic [11:0]        nx_col  [N_TRI];
  logic [11:0]        act_col [N_TRI];
  logic [N_TRI-1:0]   sh_en, nx_en, act_en;
  logic [11:0]        bg_act;

  logic               gen_vld;
  logic [COORD_W-1:0] gx, gy;
  logic [ADDR_W-1:0]  gaddr;
  logic               s1_vld;
  logic [ADDR_W-1:0]  s1_addr;
  logic [DW-1:0]      s1_dx [N_TRI][3];
  logic [DW-1:0]      s1_dy [N_TRI][3];
  logic               s2_vld;
  logic [ADDR_W-1:0]  s2_addr;
  logic [N_TRI-1:0]   s2_cov;

  logic [DW-1:0]      ex [N_TRI][3];
  logic [DW-1:0]      ey [N_TRI][3];
  logic [EW-1:0]      orient [N_TRI];
  logic [EW-1:0]      e_val  [N_TRI][3];
  logic [N_TRI-1:0]   cov;
  logic [11:0]        pix_col;

  // Low PW bits of the product of sign-extended operands are the exact signed product.
  function automatic logic [PW-1:0] smul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [PW-1:0] ae, be;
    ae = {{(PW-DW){a[DW-1]}}, a};
    be = {{(PW-DW){b[DW-1]}}, b};
    return ae * be;
  endfunction

  function automatic logic [EW-1:0] edge_val(input logic [DW-1:0] vx, input logic [DW-1:0] vy,
                                             input logic [DW-1:0] dx, input logic [DW-1:0] dy);
    logic [PW-1:0] p1, p2;
    p1 = smul(vx, dy);
    p2 = smul(vy, dx);
    return {p1[PW-1], p1} - {p2[PW-1], p2};
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept   = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: if (wr_req && wr_ack && wr_addr == LAST_ADDR) state_nx = S_DONE;
      S_DONE: begin
        accept   = start;
        state_nx = start ? S_RUN : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy    = (state == S_RUN);
  assign done    = (state == S_DONE);
  assign advance = !(wr_req && !wr_ack);

  // Shadow with this cycle's write applied, so a write alongside start lands in the active copy.
  always_comb begin
    nx_x   = sh_x;
    nx_y   = sh_y;
    nx_col = sh_col;
    nx_en  = sh_en;
    for (int i = 0; i < N_TRI; i++) begin
      if (cfg_we && cfg_idx == 3'(i)) begin
        case (cfg_sel)
          3'd0:    nx_x[i][0] = cfg_data;
          3'd1:    nx_y[i][0] = cfg_data;
          3'd2:    nx_x[i][1] = cfg_data;
          3'd3:    nx_y[i][1] = cfg_data;
          3'd4:    nx_x[i][2] = cfg_data;
          3'd5:    nx_y[i][2] = cfg_data;
          3'd6:    nx_col[i]  = cfg_data[11:0];
          default: nx_en[i]   = cfg_data[0];
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      for (int i = 0; i < N_TRI; i++) begin
        for (int k = 0; k < 3; k++) begin
          sh_x[i][k]  <= '0;
          sh_y[i][k]  <= '0;
          act_x[i][k] <= '0;
          act_y[i][k] <= '0;
        end
        sh_col[i]  <= '0;
        act_col[i] <= '0;
      end
      sh_en  <= '0;
      act_en <= '0;
      bg_act <= '0;
    end else begin
      sh_x   <= nx_x;
      sh_y   <= nx_y;
      sh_col <= nx_col;
      sh_en  <= nx_en;
      if (accept) begin
        act_x   <= nx_x;
        act_y   <= nx_y;
        act_col <= nx_col;
        act_en  <= nx_en;
        bg_act  <= bg_color;
      end
    end
  end

  // Edge vectors and orientation depend only on the active set, constant for the frame.
  always_comb begin
    for (int i = 0; i < N_TRI; i++) begin
      for (int k = 0; k < 3; k++) begin
        ex[i][k] = {1'b0, act_x[i][(k+1)%3]} - {1'b0, act_x[i][k]};
        ey[i][k] = {1'b0, act_y[i][(k+1)%3]} - {1'b0, act_y[i][k]};
      end
      orient[i] = edge_val(ex[i][0], ey[i][0],
                           {1'b0, act_x[i][2]} - {1'b0, act_x[i][0]},
                           {1'b0, act_y[i][2]} - {1'b0, act_y[i][0]});
    end
  end

  always_comb begin
    for (int i = 0; i < N_TRI; i++) begin
      cov[i] = act_en[i] && (orient[i] != '0);
      for (int k = 0; k < 3; k++) begin
        e_val[i][k] = edge_val(ex[i][k], ey[i][k], s1_dx[i][k], s1_dy[i][k]);
        if (e_val[i][k] != '0 && e_val[i][k][EW-1] != orient[i][EW-1]) cov[i] = 1'b0;
      end
    end
  end

  always_comb begin
    pix_col = bg_act;
    for (int i = N_TRI - 1; i >= 0; i--) begin
      if (s2_cov[i]) pix_col = act_col[i];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      gen_vld <= 1'b0;
      gx      <= '0;
      gy      <= '0;
      gaddr   <= '0;
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      s2_vld  <= 1'b0;
      s2_addr <= '0;
      s2_cov  <= '0;
      wr_req  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (advance) begin
        s1_vld  <= gen_vld;
        s1_addr <= gaddr;
        s2_vld  <= s1_vld;
        s2_addr <= s1_addr;
        s2_cov  <= cov;
        wr_req  <= s2_vld;
        if (s2_vld) begin
          wr_addr <= s2_addr;
          wr_data <= {4'b0, pix_col};
        end
        if (gen_vld) begin
          gaddr <= gaddr + ADDR_W'(1);
          if (gx == X_LAST) begin
            gx <= '0;
            gy <= gy + COORD_W'(1);
            if (gy == Y_LAST) gen_vld <= 1'b0;
          end else begin
            gx <= gx + COORD_W'(1);
          end
        end
      end
      if (accept) begin
        gen_vld <= 1'b1;
        gx      <= '0;
        gy      <= '0;
        gaddr   <= '0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (advance) begin
      for (int i = 0; i < N_TRI; i++) begin
        for (int k = 0; k < 3; k++) begin
          s1_dx[i][k] <= {1'b0, gx} - {1'b0, act_x[i][k]};
          s1_dy[i][k] <= {1'b0, gy} - {1'b0, act_y[i][k]};
        end
      end
    end
  end

endmodule

// File: tb/tb_tri_raster_fb.sv
// Scoreboard bench for tri_raster_fb on an 8x6 frame: golden-model expectations queued at start, checked by a monitor.
module tb_tri_raster_fb;
  localparam int H = 8, V = 6, NT = 4, CW = 12, AW = 18, NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst, cfg_we, start, wr_ack;
  logic [2:0]    cfg_idx, cfg_sel;
  logic [CW-1:0] cfg_data;
  logic [11:0]   bg_color;
  logic          busy, done, wr_req;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;

  always #5 clk = ~clk;

  tri_raster_fb #(.N_TRI(NT), .H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(CW), .ADDR_W(AW)) dut (
    .CLOCK_50(clk), .RESET(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .bg_color(bg_color), .start(start), .busy(busy), .done(done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack));

  int total = 0, passed = 0;
  int n_acc, done_cnt, ack_pct;
  bit chk_en;
  logic [33:0] q[$];
  logic [33:0] sb_exp;
  logic [15:0] got [NPIX];
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [15:0]   prev_data;

  int          sh_x [NT][3], sh_y [NT][3], ac_x [NT][3], ac_y [NT][3];
  logic [11:0] sh_col [NT], ac_col [NT];
  bit          sh_en [NT], ac_en [NT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic longint efn(longint ax, longint ay, longint bx, longint by, longint px, longint py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic logic [11:0] model_pix(int x, int y);
    longint o, e1, e2, e3;
    for (int i = 0; i < NT; i++) begin
      if (ac_en[i]) begin
        o  = efn(ac_x[i][0], ac_y[i][0], ac_x[i][1], ac_y[i][1], ac_x[i][2], ac_y[i][2]);
        e1 = efn(ac_x[i][0], ac_y[i][0], ac_x[i][1], ac_y[i][1], x, y);
        e2 = efn(ac_x[i][1], ac_y[i][1], ac_x[i][2], ac_y[i][2], x, y);
        e3 = efn(ac_x[i][2], ac_y[i][2], ac_x[i][0], ac_y[i][0], x, y);
        if ((o > 0 && e1 >= 0 && e2 >= 0 && e3 >= 0) || (o < 0 && e1 <= 0 && e2 <= 0 && e3 <= 0))
          return ac_col[i];
      end
    end
    return bg_color;
  endfunction

  // Monitor: pops expected writes, checks hold-stability during stalls, counts done pulses.
  always @(negedge clk) begin
    if (chk_en && prev_stall) begin
      check("hold_addr", wr_addr, prev_addr);
      check("hold_data", wr_data, prev_data);
    end
    if (chk_en && wr_req && wr_ack) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL extra_write: addr %0d data 0x%0h with nothing expected", wr_addr, wr_data);
      end else begin
        sb_exp = q.pop_front();
        check("wr_addr", wr_addr, 32'(sb_exp[33:16]));
        check("wr_data", wr_data, 32'(sb_exp[15:0]));
        if (wr_addr < NPIX) got[wr_addr] = wr_data;
        n_acc++;
      end
    end
    if (done) begin
      done_cnt++;
      if (chk_en) check("done_after_last", q.size(), 0);
    end
    prev_stall = wr_req && !wr_ack;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
  end

  initial begin
    ack_pct = 100;
    wr_ack  = 1'b0;
    forever begin
      @(posedge clk);
      #1 wr_ack = ($urandom_range(0, 99) < ack_pct);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    chk_en = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    for (int i = 0; i < NT; i++) begin
      for (int k = 0; k < 3; k++) begin
        sh_x[i][k] = 0; sh_y[i][k] = 0;
      end
      sh_col[i] = '0;
      sh_en[i]  = 0;
    end
    chk_en = 1;
  endtask

  task automatic cfg(input int idx, input int sel, input int data);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_sel = 3'(sel); cfg_data = CW'(data);
    @(posedge clk);
    #1 cfg_we = 1'b0;
    if (sel < 6) begin
      if (sel % 2 == 0) sh_x[idx][sel/2] = data;
      else              sh_y[idx][sel/2] = data;
    end else if (sel == 6) sh_col[idx] = 12'(data);
    else                   sh_en[idx]  = (data % 2) == 1;
  endtask

  task automatic set_tri(input int idx, input int x1, input int y1, input int x2, input int y2,
                         input int x3, input int y3, input int col, input int en);
    cfg(idx, 0, x1); cfg(idx, 1, y1); cfg(idx, 2, x2); cfg(idx, 3, y2);
    cfg(idx, 4, x3); cfg(idx, 5, y3); cfg(idx, 6, col); cfg(idx, 7, en);
  endtask

  task automatic begin_frame();
    int n;
    ac_x = sh_x; ac_y = sh_y; ac_col = sh_col; ac_en = sh_en;
    for (int a = 0; a < NPIX; a++) begin
      q.push_back({18'(a), 4'b0, model_pix(a % H, a / H)});
      got[a] = 16'hDEAD;
    end
    done_cnt = 0;
    n_acc    = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0;
    while (!wr_req && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("first_write_latency", n, 3);
  endtask

  task automatic finish_frame();
    for (int n = 0; n < 4000 && done_cnt == 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("done_seen", done_cnt, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("done_once", done_cnt, 1);
    check("all_writes_seen", q.size(), 0);
    check("idle_after_frame", {busy, wr_req}, 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_data = '0;
    start = 1'b0; bg_color = 12'h0F0; chk_en = 0; n_acc = 0; done_cnt = 0;

    // Reset and idle
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_req", wr_req, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    bad = 0;
    repeat (100) begin
      @(posedge clk);
      #1 if (busy || done || wr_req) bad++;
    end
    check("idle_quiet", bad, 0);

    // Background fill
    do_reset();
    bg_color = 12'h0F0;
    begin_frame();
    finish_frame();
    check("bg_addr0", got[0], 16'h00F0);
    check("bg_addr47", got[47], 16'h00F0);

    // Coverage and priority
    do_reset();
    set_tri(0, 1, 1, 6, 1, 1, 4, 12'h00F, 1);
    set_tri(1, 0, 0, 7, 0, 0, 5, 12'hF00, 1);
    begin_frame();
    finish_frame();
    check("pri_vertex_addr9", got[9], 16'h000F);
    check("pri_vertex_addr14", got[14], 16'h000F);
    check("slot1_addr0", got[0], 16'h0F00);
    check("slot1_addr40", got[40], 16'h0F00);
    check("bg_addr15", got[15], 16'h00F0);
    check("bg_addr47", got[47], 16'h00F0);

    // Degenerate and disabled
    do_reset();
    set_tri(0, 0, 0, 3, 3, 7, 7, 12'hABC, 1);
    set_tri(1, 1, 1, 6, 1, 1, 4, 12'h123, 0);
    begin_frame();
    finish_frame();
    bad = 0;
    for (int a = 0; a < NPIX; a++) if (got[a] !== 16'h00F0) bad++;
    check("degenerate_all_bg", bad, 0);

    // Backpressure
    do_reset();
    set_tri(0, 1, 1, 6, 1, 1, 4, 12'h00F, 1);
    set_tri(1, 0, 0, 7, 0, 0, 5, 12'hF00, 1);
    ack_pct = 30;
    begin_frame();
    finish_frame();
    check("bp_addr9", got[9], 16'h000F);
    ack_pct = 100;

    // Shadow config during busy, start during busy ignored
    do_reset();
    bg_color = 12'h000;
    set_tri(0, 0, 0, 7, 0, 0, 5, 12'h00F, 1);
    begin_frame();
    for (int n = 0; n < 200 && n_acc < 10; n++) begin
      @(posedge clk);
      #1;
    end
    cfg(0, 6, 12'h0FF);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_frame();
    check("shadow_old_colour", got[0], 16'h000F);
    begin_frame();
    finish_frame();
    check("shadow_new_colour", got[0], 16'h00FF);

    // Reset mid-frame
    do_reset();
    set_tri(0, 1, 1, 6, 1, 1, 4, 12'h00F, 1);
    bg_color = 12'h0F0;
    begin_frame();
    for (int n = 0; n < 200 && n_acc < 20; n++) @(negedge clk);
    check("reached_pixel20", n_acc >= 20, 1);
    chk_en = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_wr_req", wr_req, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    rst = 1'b0;
    q.delete();
    bad = 0;
    repeat (60) begin
      @(posedge clk);
      #1 if (busy || wr_req) bad++;
    end
    check("midrst_stays_idle", bad, 0);
    check("midrst_no_done", done_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
